mandelbrot_iterator: RTL and testbench

MANDELBROT_ITERATOR -- requirements
Module: mandelbrot_iterator

---
 rtl/mandelbrot_iterator.sv | 145 ++++++++++++++
 tb/tb_mandelbrot_iterator.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mandelbrot_iterator.sv
// Mandelbrot point iterator: computes the escape count of z <- z^2 + c in signed Q4.12.
// Starting from z = 0, one iteration is done per clock while busy. The escape test
// |z|^2 > 4.0 is checked before the iteration-limit test.
module mandelbrot_iterator (
   input  logic        clk,
   input  logic        nrst,
   input  logic        start,
   input  logic [15:0] c_re,
   input  logic [15:0] c_im,
   input  logic [7:0]  max_iter,
   output logic        busy,
   output logic        done,
   output logic [7:0]  iteration,
   output logic        ismandelbrot
);

   localparam int unsigned DW = 16;   // Q4.12 operand width
   localparam int unsigned PW = 32;   // Q8.24 product width
   localparam int unsigned MW = 33;   // magnitude sum width
   localparam int unsigned CW = 8;    // iteration count width

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ITERATE = 2'd1;
   localparam logic [1:0] S_DONE    = 2'd2;

   // 4.0 expressed in Q8.24
   localparam logic [MW-1:0] ESC_LIMIT = 33'd67108864;

   logic [1:0]           r_state;
   logic signed [DW-1:0] r_zr;
   logic signed [DW-1:0] r_zi;
   logic signed [DW-1:0] r_c_re;
   logic signed [DW-1:0] r_c_im;
   logic [CW-1:0]        r_count;
   logic [CW-1:0]        r_max_iter;

   logic [1:0]           w_state_nxt;
   logic signed [DW-1:0] w_zr_nxt;
   logic signed [DW-1:0] w_zi_nxt;
   logic signed [DW-1:0] w_c_re_nxt;
   logic signed [DW-1:0] w_c_im_nxt;
   logic [CW-1:0]        w_count_nxt;
   logic [CW-1:0]        w_max_iter_nxt;
   logic                 w_busy_nxt;
   logic                 w_done_nxt;
   logic [CW-1:0]        w_iter_nxt;
   logic                 w_mandel_nxt;

   logic signed [PW-1:0] w_zr2;
   logic signed [PW-1:0] w_zi2;
   logic signed [PW-1:0] w_zrzi;
   logic [MW-1:0]        w_mag;
   logic signed [DW-1:0] w_zr_step;
   logic signed [DW-1:0] w_zi_step;

   // Q8.24 products; both squares are non-negative so the 33-bit sum zero-extends them
   assign w_zr2  = r_zr * r_zr;
   assign w_zi2  = r_zi * r_zi;
   assign w_zrzi = r_zr * r_zi;
   assign w_mag  = {1'b0, w_zr2} + {1'b0, w_zi2};

   // Back to Q4.12: bits [27:12] of the difference and of 2*zr*zi (= bits [26:11] of zr*zi)
   assign w_zr_step = DW'((w_zr2 - w_zi2) >>> 12) + r_c_re;
   assign w_zi_step = DW'(w_zrzi >>> 11) + r_c_im;

   // Next-state and next-register logic; start is honoured only in IDLE or DONE
   always_comb begin
      w_state_nxt    = r_state;
      w_zr_nxt       = r_zr;
      w_zi_nxt       = r_zi;
      w_c_re_nxt     = r_c_re;
      w_c_im_nxt     = r_c_im;
      w_count_nxt    = r_count;
      w_max_iter_nxt = r_max_iter;
      w_busy_nxt     = 1'b0;
      w_done_nxt     = 1'b0;
      w_iter_nxt     = iteration;
      w_mandel_nxt   = ismandelbrot;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_c_re_nxt     = c_re;
               w_c_im_nxt     = c_im;
               w_max_iter_nxt = max_iter;
               w_zr_nxt       = '0;
               w_zi_nxt       = '0;
               w_count_nxt    = '0;
               w_busy_nxt     = 1'b1;
               w_state_nxt    = S_ITERATE;
            end else begin
               w_state_nxt    = S_IDLE;
            end
         end
         S_ITERATE: begin
            if (w_mag > ESC_LIMIT) begin
               w_iter_nxt   = r_count;
               w_mandel_nxt = 1'b0;
               w_done_nxt   = 1'b1;
               w_state_nxt  = S_DONE;
            end else if (r_count == r_max_iter) begin
               w_iter_nxt   = r_max_iter;
               w_mandel_nxt = 1'b1;
               w_done_nxt   = 1'b1;
               w_state_nxt  = S_DONE;
            end else begin
               w_zr_nxt     = w_zr_step;
               w_zi_nxt     = w_zi_step;
               w_count_nxt  = r_count + CW'(1);
               w_busy_nxt   = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State, datapath and registered outputs
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state      <= S_IDLE;
         r_zr         <= '0;
         r_zi         <= '0;
         r_c_re       <= '0;
         r_c_im       <= '0;
         r_count      <= '0;
         r_max_iter   <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         iteration    <= '0;
         ismandelbrot <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_zr         <= w_zr_nxt;
         r_zi         <= w_zi_nxt;
         r_c_re       <= w_c_re_nxt;
         r_c_im       <= w_c_im_nxt;
         r_count      <= w_count_nxt;
         r_max_iter   <= w_max_iter_nxt;
         busy         <= w_busy_nxt;
         done         <= w_done_nxt;
         iteration    <= w_iter_nxt;
         ismandelbrot <= w_mandel_nxt;
      end
   end

endmodule

// File: tb/tb_mandelbrot_iterator.sv
// Directed bench for mandelbrot_iterator with hand-computed escape counts and latencies.
module tb_mandelbrot_iterator;

   logic        clk = 1'b0;
   logic        nrst;
   logic        start;
   logic [15:0] c_re;
   logic [15:0] c_im;
   logic [7:0]  max_iter;
   logic        busy;
   logic        done;
   logic [7:0]  iteration;
   logic        ismandelbrot;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mandelbrot_iterator dut (
      .clk          (clk),
      .nrst         (nrst),
      .start        (start),
      .c_re         (c_re),
      .c_im         (c_im),
      .max_iter     (max_iter),
      .busy         (busy),
      .done         (done),
      .iteration    (iteration),
      .ismandelbrot (ismandelbrot)
   );

   // Single comparison point: counts and reports mismatches
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Present operands with start for one rising edge (called just after an edge)
   task automatic start_point(input logic [15:0] re, input logic [15:0] im, input logic [7:0] mi);
      c_re     = re;
      c_im     = im;
      max_iter = mi;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
   endtask

   // Wait for done; edges counts rising edges with the start-sampling edge as 1
   task automatic wait_result(input string tag, input logic [7:0] e_iter, input logic e_mandel,
                              input int e_edges, input int edges0, input bit post);
      int edges;
      int busy_cnt;
      edges    = edges0;
      busy_cnt = edges0 - 1;
      while (!done && edges < 600) begin
         if (busy) busy_cnt++;
         @(posedge clk);
         #1;
         edges++;
      end
      check({tag, "/done"},   32'(done), 32'd1);
      check({tag, "/edges"},  32'(edges), 32'(e_edges));
      check({tag, "/busy_n"}, 32'(busy_cnt), 32'(e_edges - 1));
      check({tag, "/busy0"},  32'(busy), 32'd0);
      check({tag, "/iter"},   32'(iteration), 32'(e_iter));
      check({tag, "/mandel"}, 32'(ismandelbrot), 32'(e_mandel));
      if (post) begin
         @(posedge clk);
         #1;
         check({tag, "/pulse"},  32'(done), 32'd0);
         check({tag, "/idle"},   32'(busy), 32'd0);
         check({tag, "/hold_i"}, 32'(iteration), 32'(e_iter));
         check({tag, "/hold_m"}, 32'(ismandelbrot), 32'(e_mandel));
      end
   endtask

   initial begin
      nrst     = 1'b0;
      start    = 1'b0;
      c_re     = '0;
      c_im     = '0;
      max_iter = '0;
      #1;
      check("rst/busy",   32'(busy), 32'd0);
      check("rst/done",   32'(done), 32'd0);
      check("rst/iter",   32'(iteration), 32'd0);
      check("rst/mandel", 32'(ismandelbrot), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      nrst = 1'b1;
      @(posedge clk);
      #1;

      // Origin never escapes: limit reached at count 50
      start_point(16'h0000, 16'h0000, 8'd50);
      wait_result("c0", 8'd50, 1'b1, 52, 1, 1'b1);

      // c = 1.0: |z|^2 == 4.0 at count 2 stays, escapes at count 3
      start_point(16'h1000, 16'h0000, 8'd50);
      wait_result("c1", 8'd3, 1'b0, 5, 1, 1'b1);

      // c = -2.0: orbit sticks at z = 2 on the boundary
      start_point(16'hE000, 16'h0000, 8'd255);
      wait_result("cm2", 8'd255, 1'b1, 257, 1, 1'b1);

      // c = 3.0 with limits 0 and 1
      start_point(16'h3000, 16'h0000, 8'd0);
      wait_result("c3m0", 8'd0, 1'b1, 2, 1, 1'b1);
      start_point(16'h3000, 16'h0000, 8'd1);
      wait_result("c3m1", 8'd1, 1'b0, 3, 1, 1'b1);

      // start pulsed while busy must not disturb the c = 1.0 run
      start_point(16'h1000, 16'h0000, 8'd50);
      for (int i = 0; i < 2; i++) begin
         c_re     = 16'h3000;
         max_iter = 8'd0;
         start    = 1'b1;
         @(posedge clk);
         #1;
         check("ign/busy", 32'(busy), 32'd1);
         check("ign/done", 32'(done), 32'd0);
      end
      start = 1'b0;
      wait_result("ign", 8'd3, 1'b0, 5, 3, 1'b0);

      // start in the DONE cycle: back-to-back run with no idle gap
      c_re     = 16'h3000;
      c_im     = 16'h0000;
      max_iter = 8'd1;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("b2b/busy",   32'(busy), 32'd1);
      check("b2b/done",   32'(done), 32'd0);
      check("b2b/hold_i", 32'(iteration), 32'd3);
      check("b2b/hold_m", 32'(ismandelbrot), 32'd0);
      wait_result("b2b", 8'd1, 1'b1 ^ 1'b1, 3, 1, 1'b1);

      // Reset five cycles into an iteration aborts it with outputs cleared at once
      start_point(16'h0000, 16'h0000, 8'd50);
      repeat (4) @(posedge clk);
      #1;
      check("abort/busy_pre", 32'(busy), 32'd1);
      nrst = 1'b0;
      #1;
      check("abort/busy",   32'(busy), 32'd0);
      check("abort/done",   32'(done), 32'd0);
      check("abort/iter",   32'(iteration), 32'd0);
      check("abort/mandel", 32'(ismandelbrot), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("abort/nodone", 32'(done), 32'd0);
      end
      nrst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         check("abort/quiet", 32'(done | busy), 32'd0);
      end
      start_point(16'h1000, 16'h0000, 8'd50);
      wait_result("post_rst", 8'd3, 1'b0, 5, 1, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
